flatten_stream: RTL and testbench
=================================

# flatten_stream

Downstream of the pooling stage: turns the pooled feature map into the flat element stream the dense (fully-connected) layer consumes. Each pooled pixel arrives as one `i_data`/`i_valid` beat carrying all channels. Pixels are written into a two-bank frame buffer. A full bank is read out one DATA_WIDTH element at a time over a valid/ready handshake, with `o_last` on the final element of each frame. Two banks let frame k+1 be captured while frame k drains.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per channel element
- IN_WIDTH, 15, pooled map width (pixels per row)
- IN_HEIGHT, 15, pooled map height (rows per frame)
- IN_CHANNEL, 3, channels per pixel

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- i_data  input  DATA_WIDTH*IN_CHANNEL  pooled pixel; channel c at bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH]
- i_valid  input  1  single-cycle pixel strobe; no backpressure upstream
- o_data  output  DATA_WIDTH  flattened element
- o_valid  output  1  element valid; held until accepted
- i_ready  input  1  dense layer ready
- o_last  output  1  high with o_valid on the final element of a frame
- o_overflow  output  1  sticky: a pixel arrived while both banks were full

## Operation
- Constants and counter widths:
  - NPIX = IN_WIDTH*IN_HEIGHT.
  - Pixel counters are $clog2(NPIX) bits wide; the channel counter is max(1,$clog2(IN_CHANNEL)) bits wide.
- Write side:
  - `wr_bank` and `wr_pix` select the RAM word written on each accepted `i_valid`; `wr_pix` increments per write.
  - When `wr_pix` reaches NPIX-1: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_pix` to 0.
- Drop rule: if `full[wr_bank]` is set, the pixel is discarded, `wr_pix` holds, and `o_overflow` is set. It clears only on reset.
- Read FSM states: IDLE, FETCH, PRESENT.
  - IDLE → FETCH when `full[rd_bank]` is set.
  - FETCH: read enable asserted with address {rd_bank, rd_pix}; next state PRESENT.
  - PRESENT: `o_valid`=1. `o_data` is the `rd_ch` slice of the registered RAM output, and the RAM output holds because read enable is low.
  - On `o_valid && i_ready` in PRESENT:
    - last element: clear `full[rd_bank]`, toggle `rd_bank`, zero both counters, go to IDLE;
    - otherwise: advance the counters and go to FETCH.
- Default element order (CHW): `rd_pix` runs fastest, wrapping at NPIX-1; `rd_ch` increments on each `rd_pix` wrap. Element index = c*NPIX + pixel.
- `o_last` = PRESENT && `rd_pix`==NPIX-1 && `rd_ch`==IN_CHANNEL-1.
- Simultaneous events in one cycle:
  - A write completing a frame and a read releasing the other bank both take effect; no overflow.
  - A write to a bank that is being released that same cycle is still dropped (the full flag is sampled pre-edge).
- Reset, including mid-frame: `full`=00, both banks 0, all counters 0, FSM IDLE. Partial frames are discarded. RAM contents are not cleared.

## Timing
- Reset values: `o_valid`=0, `o_last`=0, `o_overflow`=0, `o_data`=0 (RAM output register reset).
- Latency: if the frame's final `i_valid` is in cycle N, `full` is visible in N+1 (IDLE→FETCH), FETCH is in N+2, and the first `o_valid` is in N+3.
- Throughput: one element per 2 cycles with `i_ready` held high. A frame drains in 2*NPIX*IN_CHANNEL cycles plus stall cycles.
- Output stability: `o_data` and `o_last` are stable while `o_valid`=1 and `i_ready`=0.
- Input rate: `i_valid` accepted every cycle; the write path never stalls.

## Configuration
- Macro: `FLATTEN_HWC_ORDER_EN`.
- Defined: HWC order. `rd_ch` runs fastest, wrapping at IN_CHANNEL-1, and `rd_pix` increments on each channel wrap. Element index = pixel*IN_CHANNEL + c. `o_last` is unchanged: final pixel, final channel.
- Undefined: CHW order as described under Operation.

## Test plan
Bench config: IN_WIDTH=2, IN_HEIGHT=2, IN_CHANNEL=3. Pixel k, channel c carries byte 16*k+c.
- Basic CHW frame: 4 back-to-back pixels, `i_ready`=1.
  - First `o_valid` 3 cycles after the last pixel.
  - Output sequence 00,10,20,30,01,11,21,31,02,12,22,32 at 2-cycle spacing.
  - `o_last` only on 32.
- HWC build (`FLATTEN_HWC_ORDER_EN` defined), same stimulus → 00,01,02,10,11,12,20,21,22,30,31,32; `o_last` on 32.
- Backpressure: drop `i_ready` for 5 cycles while the element 20 is presented → 20 held stable, nothing lost or duplicated, sequence completes.
- Double buffering: 8 pixels back-to-back (two frames), second frame bytes +0x40 → frame 1 stream, then frame 2 (40..72) immediately after; `o_overflow`=0.
- Overflow: `i_ready`=0, send 12 pixels → pixels 9-12 dropped and `o_overflow`=1. After both frames drain, the next frame is written to bank 0 correctly and `o_overflow` stays 1.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle during PRESENT → next cycle `o_valid`=0, `o_last`=0, `o_overflow`=0. A following full frame streams from element 00.

Source files
------------

// File: rtl/flatten_stream.sv
// flatten_stream: two-bank frame buffer turning pooled pixels into a flat element stream.
// Default order is CHW; define FLATTEN_HWC_ORDER_EN for HWC order.
module flatten_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH = 15,
  parameter int IN_HEIGHT = 15,
  parameter int IN_CHANNEL = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*IN_CHANNEL-1:0] i_data,
  input  logic                             i_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_last,
  output logic                             o_overflow
);
  localparam int NPIX = IN_WIDTH * IN_HEIGHT;
  localparam int PW = $clog2(NPIX);
  localparam int CW = IN_CHANNEL > 1 ? $clog2(IN_CHANNEL) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH*IN_CHANNEL-1:0] mem [2**(PW+1)];
  logic [DATA_WIDTH*IN_CHANNEL-1:0] rd_q;
  logic [1:0] full;
  logic wr_bank, rd_bank;
  logic [PW-1:0] wr_pix, rd_pix, pix_nx;
  logic [CW-1:0] rd_ch, ch_nx;
  logic wr_en, wr_done, pix_end, ch_end, accept, rd_done;
  assign wr_en = i_valid && !full[wr_bank];
  assign wr_done = wr_en && wr_pix == PW'(NPIX - 1);
  assign pix_end = rd_pix == PW'(NPIX - 1);
  assign ch_end = rd_ch == CW'(IN_CHANNEL - 1);
  assign o_valid = state == PRESENT;
  assign o_last = o_valid && pix_end && ch_end;
  assign accept = o_valid && i_ready;
  assign rd_done = accept && o_last;
  assign o_data = rd_q[DATA_WIDTH*int'(rd_ch) +: DATA_WIDTH];
`ifdef FLATTEN_HWC_ORDER_EN
  assign pix_nx = ch_end ? rd_pix + 1'b1 : rd_pix;
  assign ch_nx = ch_end ? '0 : rd_ch + 1'b1;
`else
  assign pix_nx = pix_end ? '0 : rd_pix + 1'b1;
  assign ch_nx = pix_end ? rd_ch + 1'b1 : rd_ch;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (full[rd_bank] ? FETCH : IDLE) :
               state == FETCH ? PRESENT :
               accept         ? (rd_done ? IDLE : FETCH) : PRESENT;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[{wr_bank, wr_pix}] <= i_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_pix <= '0;
      rd_pix <= '0;
      rd_ch <= '0;
      rd_q <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      // full flags are sampled pre-edge, so a write to a bank released this cycle is dropped
      full <= (full | (2'(wr_done) << wr_bank)) & ~(2'(rd_done) << rd_bank);
      if (i_valid && full[wr_bank]) o_overflow <= 1'b1;
      if (wr_en) begin
        wr_pix <= wr_done ? '0 : wr_pix + 1'b1;
        wr_bank <= wr_bank ^ wr_done;
      end
      if (state == FETCH) rd_q <= mem[{rd_bank, rd_pix}];
      if (accept) begin
        rd_pix <= rd_done ? '0 : pix_nx;
        rd_ch <= rd_done ? '0 : ch_nx;
        rd_bank <= rd_bank ^ rd_done;
      end
    end
  end
endmodule

// File: tb/tb_flatten_stream.sv
// tb_flatten_stream: table-driven and randomized checks of flatten_stream against a frame-level model.
module tb_flatten_stream;
  localparam int DW = 8, W = 2, H = 2, C = 3, NPIX = W * H, NE = NPIX * C;
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 0;
  logic [DW*C-1:0] i_data = '0;
  logic [DW-1:0] o_data;
  logic o_valid, o_last, o_overflow;
  int total = 0, bad = 0;

  flatten_stream #(.DATA_WIDTH(DW), .IN_WIDTH(W), .IN_HEIGHT(H), .IN_CHANNEL(C)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .o_overflow(o_overflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: complete frames become an ordered element queue;
  // a pixel is lost whenever two captured frames are still unreleased.
  logic [DW*C-1:0] part[$];
  logic [DW:0] expq[$];
  int fc = 0;
  logic exp_ovf = 0, stall = 0;
  logic [DW:0] held;
  always @(negedge clk) begin
    logic rel;
    rel = 0;
    if (!rst_n) begin
      part.delete(); expq.delete(); fc = 0; exp_ovf = 0; stall = 0;
    end else begin
      chk("overflow_flag", o_overflow, exp_ovf);
      if (stall) chk("held_output", {o_valid, o_last, o_data}, {1'b1, held});
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_element: got %0h want none at %0t", o_data, $time);
        end else begin
          chk("element", {o_last, o_data}, expq[0]);
          rel = expq[0][DW];
          void'(expq.pop_front());
        end
      end
      stall = o_valid && !i_ready;
      held = {o_last, o_data};
      if (i_valid) begin
        if (fc == 2) exp_ovf = 1;
        else begin
          part.push_back(i_data);
          if (part.size() == NPIX) begin
            for (int e = 0; e < NE; e++) begin
              int p, c;
`ifdef FLATTEN_HWC_ORDER_EN
              p = e / C; c = e % C;
`else
              c = e / NPIX; p = e % NPIX;
`endif
              expq.push_back({e == NE - 1, part[p][c*DW +: DW]});
            end
            part.delete();
            fc++;
          end
        end
      end
      if (rel) fc--;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] off);
    for (int c = 0; c < C; c++) i_data[c*DW +: DW] = 8'(16 * k + c) + off;
    i_valid = 1;
    tick();
    i_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] off);
    for (int k = 0; k < NPIX; k++) send(k, off);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    i_ready = 1;
    while ((expq.size() != 0 || o_valid) && n < 400) begin tick(); n++; end
    chk({nm, "_drained"}, 32'(n < 400), 1);
  endtask

  typedef struct {logic v; logic [7:0] d; logic l;} vec_t;
  vec_t tbl[25];
  logic [7:0] ord[NE];

  initial begin
    int n, j;
    logic [7:0] pred;
`ifdef FLATTEN_HWC_ORDER_EN
    ord = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
`else
    ord = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};
`endif
    for (int i = 0; i < 25; i++) begin
      tbl[i].v = i >= 2 && i % 2 == 0;
      tbl[i].d = tbl[i].v ? ord[(i-2)/2] : 8'h00;
      tbl[i].l = i == 24;
    end
    // reset values
    tick(2);
    rst_n = 1;
    @(negedge clk);
    chk("reset_outputs", {o_valid, o_last, o_overflow, o_data}, 0);
    tick();
    // basic frame: cycle-by-cycle table starting the cycle after the last pixel
    i_ready = 1;
    send_frame(8'h00);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("basic_valid_%0d", i), o_valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("basic_data_%0d", i), o_data, tbl[i].d);
      chk($sformatf("basic_last_%0d", i), o_last, tbl[i].l);
    end
    tick();
    drain("basic");
    // backpressure on element 20
    j = 0;
    for (int i = 0; i < NE; i++) if (ord[i] == 8'h20) j = i;
    pred = ord[j-1];
    send_frame(8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!(o_valid && o_data == pred) && n < 100);
    chk("bp_pred_seen", 32'(n < 100), 1);
    tick();
    i_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall", {o_valid, o_data}, {1'b1, 8'h20});
      tick();
    end
    drain("bp");
    // double buffering
    send_frame(8'h00);
    send_frame(8'h40);
    n = 0;
    do begin @(negedge clk); n++; end while (!(o_valid && i_ready && o_last) && n < 200);
    chk("dbl_first_last", 32'(n < 200), 1);
    @(negedge clk); chk("dbl_gap_idle", o_valid, 0);
    @(negedge clk); chk("dbl_gap_fetch", o_valid, 0);
    @(negedge clk); chk("dbl_second_start", {o_valid, o_data}, {1'b1, 8'h40});
    tick();
    drain("dbl");
    chk("dbl_no_overflow", o_overflow, 0);
    // overflow: 12 pixels with no drain
    i_ready = 0;
    for (int k = 0; k < 12; k++) send(k, 8'h00);
    @(negedge clk);
    chk("ovf_set", o_overflow, 1);
    tick();
    drain("ovf");
    send_frame(8'h80);
    drain("ovf_after");
    chk("ovf_sticky", o_overflow, 1);
    // reset mid-stream while presenting
    i_ready = 0;
    send_frame(8'hC0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid && n < 20);
    chk("rst_present_seen", 32'(n < 20), 1);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_outputs", {o_valid, o_last, o_overflow}, 0);
    tick();
    i_ready = 1;
    send_frame(8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid && n < 20);
    chk("rst_restart_first", {o_valid, o_data}, {1'b1, 8'h00});
    tick();
    drain("rst");
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data = 24'($urandom);
      i_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    i_valid = 0;
    drain("random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
